// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL phase-step controller.
// Imported by the controller top and the per-output position counter.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_LOCKW,
    S_FIN
  } state_t;

  function automatic int pw(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic int cyc_w(input int p, input int g, input int l);
    int m;
    m = p;
    if (g > m) m = g;
    if (l > m) m = l;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_phase_pos_cnt.sv
// Single-channel phase position counter, modulo PHASE_STEPS, up/down.
// Explicit end-point compares keep non-power-of-two moduli correct.
module pll_phase_pos_cnt
  import pll_ctrl_pkg::*;
#(
  parameter int PHASE_STEPS = 8,
  parameter int PW          = pw(PHASE_STEPS)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          en,
  input  logic          dir,
  output logic [PW-1:0] pos
);

  localparam logic [PW-1:0] POS_MAX = PW'(PHASE_STEPS - 1);

  logic [PW-1:0] pos_q;
  logic [PW-1:0] pos_d;

  always_comb begin
    pos_d = pos_q;
    if (en) begin
      if (dir) begin
        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
      end else begin
        pos_d = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/pll_phase_step_ctrl.sv
// Sequencer for the CCC PLL dynamic phase-rotate pins: spaced ROTATE
// pulses per request, per-output position tracking, then lock wait.
module pll_phase_step_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int CNT_W       = 8,
  parameter int PHASE_STEPS = 8,
  parameter int PULSE_CYC   = 2,
  parameter int GAP_CYC     = 4,
  parameter int LOCK_TO     = 1024,
  localparam int PW         = pw(PHASE_STEPS)
) (
  input  logic                  CLK,
  input  logic                  ARST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [NUM_OUT-1:0]    REQ_SEL,
  input  logic                  REQ_DIR,
  input  logic [CNT_W-1:0]      REQ_STEPS,
  input  logic                  PLL_LOCK,
  output logic [NUM_OUT-1:0]    PHASE_OUT_SEL,
  output logic                  PHASE_DIRECTION,
  output logic                  PHASE_ROTATE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  input  logic                  ERR_CLR,
  output logic [NUM_OUT*PW-1:0] PHASE_POS
);

  localparam int CW = cyc_w(PULSE_CYC, GAP_CYC, LOCK_TO);

  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] L_LAST = CW'(LOCK_TO - 1);

  state_t               state_q, state_d;
  logic [NUM_OUT-1:0]   sel_q, sel_d;
  logic                 dir_q, dir_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic                 err_set;
  logic                 pos_step;
  logic                 drive_pins;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    err_set  = 1'b0;
    pos_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          sel_d   = REQ_SEL;
          dir_d   = REQ_DIR;
          rem_d   = REQ_STEPS;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (REQ_STEPS == '0 || REQ_SEL == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        cnt_d = '0;
        if (!PLL_LOCK) begin
          err_set = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        // A lock loss here is remembered; the pulse still runs full width.
        if (!PLL_LOCK) begin
          err_set = 1'b1;
          abort_d = 1'b1;
        end
        if (cnt_q == P_LAST) begin
          cnt_d    = '0;
          pos_step = 1'b1;
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end
          if (abort_q || !PLL_LOCK) begin
            state_d = S_FIN;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (!PLL_LOCK) begin
          err_set = 1'b1;
          state_d = S_FIN;
        end else if (cnt_q == G_LAST) begin
          cnt_d   = '0;
          state_d = (rem_q != '0) ? S_PULSE : S_LOCKW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOCKW: begin
        if (PLL_LOCK) begin
          state_d = S_FIN;
        end else if (cnt_q == L_LAST) begin
          err_set = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (err_set) begin
      err_d = 1'b1;
    end else if (ERR_CLR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign drive_pins = (state_q == S_SETUP) || (state_q == S_PULSE) ||
                      (state_q == S_GAP)   || (state_q == S_LOCKW);

  assign REQ_READY       = (state_q == S_IDLE);
  assign BUSY            = (state_q != S_IDLE);
  assign DONE            = (state_q == S_FIN);
  assign PHASE_ROTATE    = (state_q == S_PULSE);
  assign PHASE_OUT_SEL   = drive_pins ? sel_q : '0;
  assign PHASE_DIRECTION = drive_pins ? dir_q : 1'b0;
  assign ERR             = err_q;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_pos
    pll_phase_pos_cnt #(
      .PHASE_STEPS(PHASE_STEPS),
      .PW         (PW)
    ) u_pos (
      .clk (CLK),
      .arst(ARST),
      .en  (pos_step & sel_q[i]),
      .dir (dir_q),
      .pos (PHASE_POS[i*PW +: PW])
    );
  end

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Scoreboard bench for pll_phase_step_ctrl: directed requests push
// expected completions; a negedge monitor checks them on DONE.
module tb_pll_phase_step_ctrl;

  localparam int PULSE = 2;
  localparam int GAP   = 4;

  typedef struct {
    logic [3:0]  sel;
    logic        dir;
    int          lat;
    int          pulses;
    logic        err;
    logic [11:0] pos;
  } exp_t;

  logic        CLK = 1'b0;
  logic        ARST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [3:0]  REQ_SEL;
  logic        REQ_DIR;
  logic [7:0]  REQ_STEPS;
  logic        PLL_LOCK;
  logic [3:0]  PHASE_OUT_SEL;
  logic        PHASE_DIRECTION;
  logic        PHASE_ROTATE;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic        ERR_CLR;
  logic [11:0] PHASE_POS;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  pll_phase_step_ctrl #(
    .NUM_OUT    (4),
    .CNT_W      (8),
    .PHASE_STEPS(8),
    .PULSE_CYC  (PULSE),
    .GAP_CYC    (GAP),
    .LOCK_TO    (16)
  ) dut (
    .CLK            (CLK),
    .ARST           (ARST),
    .REQ_VALID      (REQ_VALID),
    .REQ_READY      (REQ_READY),
    .REQ_SEL        (REQ_SEL),
    .REQ_DIR        (REQ_DIR),
    .REQ_STEPS      (REQ_STEPS),
    .PLL_LOCK       (PLL_LOCK),
    .PHASE_OUT_SEL  (PHASE_OUT_SEL),
    .PHASE_DIRECTION(PHASE_DIRECTION),
    .PHASE_ROTATE   (PHASE_ROTATE),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .ERR            (ERR),
    .ERR_CLR        (ERR_CLR),
    .PHASE_POS      (PHASE_POS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int p0, input int p1,
                                     input int p2, input int p3);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  // Monitor: tracks pulse widths, gaps and latency, checks on DONE.
  int  lat, pulses, rot_run, gap_run;
  bit  active = 0;
  always @(negedge CLK) begin
    if (ARST) begin
      active  = 0;
      rot_run = 0;
      gap_run = 0;
    end else begin
      if (active) begin
        lat++;
        if (PHASE_ROTATE) begin
          if (rot_run == 0) begin
            if (pulses > 0) chk("gap_width", gap_run, GAP);
            if (exp_q.size() > 0) begin
              chk("rot_sel", PHASE_OUT_SEL, exp_q[0].sel);
              chk("rot_dir", PHASE_DIRECTION, exp_q[0].dir);
            end
          end
          rot_run++;
          gap_run = 0;
        end else begin
          if (rot_run != 0) begin
            chk("pulse_width", rot_run, PULSE);
            pulses++;
          end
          rot_run = 0;
          gap_run++;
        end
        if (DONE) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got DONE expected none");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_latency", lat, e.lat);
            chk("pulse_count", pulses, e.pulses);
            chk("err_at_done", ERR, e.err);
            chk("phase_pos", PHASE_POS, e.pos);
            chk("fin_rotate", PHASE_ROTATE, 0);
          end
          active = 0;
          done_cnt++;
        end
      end
      if (REQ_VALID && REQ_READY) begin
        active  = 1;
        lat     = 0;
        pulses  = 0;
        rot_run = 0;
        gap_run = 0;
      end
    end
  end

  task automatic send(input logic [3:0] sel, input logic dir,
                      input logic [7:0] steps, input bit push,
                      input int lat_e, input int pulses_e,
                      input logic err_e, input logic [11:0] pos_e);
    exp_t e;
    e.sel = sel; e.dir = dir; e.lat = lat_e;
    e.pulses = pulses_e; e.err = err_e; e.pos = pos_e;
    if (push) exp_q.push_back(e);
    @(posedge CLK); #1;
    REQ_VALID = 1; REQ_SEL = sel; REQ_DIR = dir; REQ_STEPS = steps;
    @(posedge CLK); #1;
    REQ_VALID = 0;
  endtask

  task automatic wait_done(input string name);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < 300) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (done_cnt == n0) begin
      errors++;
      $display("FAIL %s_timeout: got no DONE expected DONE", name);
    end
  endtask

  initial begin
    ARST = 1; REQ_VALID = 0; REQ_SEL = 0; REQ_DIR = 0;
    REQ_STEPS = 0; PLL_LOCK = 1; ERR_CLR = 0;
    #2;
    chk("rst_ready", REQ_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_rotate", PHASE_ROTATE, 0);
    chk("rst_pos", PHASE_POS, 0);
    chk("rst_err", ERR, 0);
    @(posedge CLK); #1;
    ARST = 0;

    // 3 steps advance on output 0
    send(4'b0001, 1, 3, 1, 21, 3, 0, pk(3, 0, 0, 0));
    wait_done("adv3");

    // 10 steps retard on outputs 1 and 2, wraps to 6
    send(4'b0110, 0, 10, 1, 63, 10, 0, pk(3, 6, 6, 0));
    wait_done("ret10");

    // Zero steps, then empty select: nothing rotates
    send(4'b1111, 1, 0, 1, 1, 0, 0, pk(3, 6, 6, 0));
    wait_done("zero_steps");
    send(4'b0000, 1, 5, 1, 1, 0, 0, pk(3, 6, 6, 0));
    wait_done("zero_sel");

    // Lock lost in 2nd cycle of 2nd pulse: pulse completes, abort
    send(4'b0001, 1, 5, 1, 10, 2, 1, pk(5, 6, 6, 0));
    repeat (8) @(posedge CLK);
    #1 PLL_LOCK = 0;
    wait_done("lock_drop");
    PLL_LOCK = 1;
    chk("err_sticky", ERR, 1);
    @(posedge CLK); #1 ERR_CLR = 1;
    @(posedge CLK); #1 ERR_CLR = 0;
    chk("err_clr", ERR, 0);

    // Lock absent after the last gap: 16-cycle timeout in LOCKW
    send(4'b1000, 1, 1, 1, 24, 1, 1, pk(5, 6, 6, 1));
    repeat (7) @(posedge CLK);
    #1 PLL_LOCK = 0;
    wait_done("lock_to");
    PLL_LOCK = 1;
    @(posedge CLK); #1 ERR_CLR = 1;
    @(posedge CLK); #1 ERR_CLR = 0;
    chk("err_clr2", ERR, 0);

    // Async reset in the middle of a gap
    send(4'b1111, 1, 4, 0, 0, 0, 0, 0);
    repeat (4) @(posedge CLK);
    #1;
    chk("pre_rst_busy", BUSY, 1);
    chk("pre_rst_sel", PHASE_OUT_SEL, 4'b1111);
    ARST = 1;
    #1;
    chk("mid_rst_ready", REQ_READY, 1);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_sel", PHASE_OUT_SEL, 0);
    chk("mid_rst_rot", PHASE_ROTATE, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_pos", PHASE_POS, 0);
    @(posedge CLK); #1;
    ARST = 0;

    // After reset: one retard step wraps output 0 to 7
    send(4'b0001, 0, 1, 1, 9, 1, 0, pk(7, 0, 0, 0));
    wait_done("post_rst");

    repeat (3) @(posedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
